assoc_dcache: RTL and testbench
===============================

Name: assoc_dcache

Overview:
Parametrised set-associative, write-back, write-allocate data cache with a blocking miss FSM. It sits between the core's memory stage and the block-wide main-memory interface. It replaces the fixed 2-way, same-cycle-fetch cache with a parametrised block that has explicit valid/ready handshakes on both sides. It also adds a stall output, a reset, victim selection that prefers invalid ways, and multi-cycle writeback/refill sequencing.

Parameters:
DATA_WIDTH, 32, word width in bits (fixed at 32 for RV32 load/store decode).
ADDR_WIDTH, 32, byte address width.
WAYS, 2, associativity; a power of 2 in the range 1..8.
NUM_SETS, 128, number of sets; a power of 2.
BLOCK_WORDS, 4, words per line; a power of 2 in the range 2..16.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
req_valid  in  1  core request present.
req_write  in  1  1 = store, 0 = load.
req_addr  in  ADDR_WIDTH  byte address.
req_wdata  in  DATA_WIDTH  store data, right-aligned.
req_funct3  in  3  RV32 load/store funct3.
req_ready  out  1  cache can accept a request this cycle; the core stalls when this is low.
resp_valid  out  1  one-cycle pulse: load data or store completion.
resp_rdata  out  DATA_WIDTH  extended load data; 0 for stores.
mem_req_valid  out  1  memory request pending.
mem_req_write  out  1  1 = writeback of a line, 0 = refill read.
mem_req_addr  out  ADDR_WIDTH  line-aligned address (low offset bits are 0).
mem_wdata  out  BLOCK_WORDS*DATA_WIDTH  writeback line; word i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
mem_req_ready  in  1  memory accepts the request.
mem_resp_valid  in  1  refill data valid (single-cycle pulse).
mem_rdata  in  BLOCK_WORDS*DATA_WIDTH  refill line, packed the same way as mem_wdata.

Behaviour:
- Address split:
  - byte offset = addr[1:0].
  - word offset = next log2(BLOCK_WORDS) bits.
  - index = next log2(NUM_SETS) bits.
  - tag = remaining upper bits.
- State per set and way: valid, dirty, tag, data. Per set: a round-robin victim pointer.
- Reset: valid, dirty and victim pointers are cleared, FSM goes to IDLE. All outputs are 0 except req_ready, which is 1 from the first cycle after reset. Data array contents are don't-care.
- req_ready = (state == IDLE) && !rst. A request is accepted when req_valid && req_ready; address, data, funct3 and the write flag are latched at acceptance.
- Hit (tag compared combinationally in IDLE):
  - Load: resp_valid=1 the next cycle with the extended word.
  - Store: the byte/half/word is merged at the acceptance edge, dirty is set, and resp_valid=1 the next cycle.
  - Back-to-back hits sustain one request per cycle.
- Miss: state goes to WRITEBACK if the chosen victim is valid and dirty, otherwise to REFILL_REQ. req_ready is low until RESPOND completes.
- Victim selection: the lowest-index invalid way; if all ways are valid, the way given by the set's victim pointer. The pointer advances modulo WAYS on every install.
- WRITEBACK:
  - mem_req_valid=1, mem_req_write=1, mem_req_addr={victim tag, index, 0}, mem_wdata = victim line.
  - All fields are held stable until mem_req_ready; on that handshake go to REFILL_REQ.
- REFILL_REQ: mem_req_valid=1, mem_req_write=0, line address of the request; on handshake go to REFILL_WAIT.
- REFILL_WAIT: on mem_resp_valid, install mem_rdata into the victim way, set valid=1 and the new tag.
  - Load miss: dirty=0.
  - Store miss: the store is merged into the installed line and dirty=1.
  - Then go to RESPOND.
- RESPOND: resp_valid=1 (load data is taken from the installed line), then return to IDLE.
- mem_resp_valid outside REFILL_WAIT is ignored.
- Load extension:
  - 000 LB: sign-extend the byte at byte offset.
  - 001 LH: sign-extend the half selected by addr[1].
  - 010 LW: whole word.
  - 100 LBU: zero-extend the byte.
  - 101 LHU: zero-extend the half.
  - Any other funct3: whole word.
- Store width: 000 SB, 001 SH (half selected by addr[1]), 010 SW; any other funct3 is treated as SW. Misalignment is ignored, with no trap.
- Reset mid-operation: the FSM returns to IDLE and mem_req_valid drops the next cycle. Any in-flight transaction is abandoned, dirty data is lost, and memory must discard the transaction.
- rst has priority over every other input in the same cycle.

Test Plan:
- After reset, LW 0x100 → read request to 0x100. Memory returns {0x11111111, 0x22222222, 0x33333333, 0x44444444} for words 0..3 → resp_rdata=0x11111111. Then LW 0x104 → hit, resp_rdata=0x22222222 after 1 cycle, no memory request.
- SB 0x101 with data 0xAB on a resident line. Then LBU 0x101 → 0x000000AB, and LB 0x101 → 0xFFFFFFAB. Neighbouring bytes are unchanged.
- Conflict test, addresses all mapping to index 0x10:
  - SW 0x100 = 0xDEADBEEF, then LW 0x900 fills way 1.
  - LW 0x1100 evicts way 0: writeback to 0x100 with word 0 = 0xDEADBEEF, then a refill of 0x1100.
- Backpressure: hold mem_req_ready=0 for 5 cycles during WRITEBACK → mem_req_addr and mem_wdata stay stable, req_ready=0, and no resp_valid is asserted.
- SH 0x106 = 0xBEEF on a miss (write-allocate) → refill, then merge. A later LHU 0x106 → 0x0000BEEF; evicting that line produces a writeback.
- Assert rst during REFILL_WAIT → next cycle mem_req_valid=0 and req_ready=1. A subsequent LW 0x104 misses.

Source files
------------

// File: rtl/assoc_dcache_if.sv
`default_nettype none
// ============================================================================
//  Module      : assoc_dcache_if
//  Description : Core-side request/response and line-wide memory-side
//                handshake bundle for the set-associative data cache.
//  Revision    : 1.0 - initial release
// ============================================================================
interface assoc_dcache_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int BLOCK_WORDS = 4
);
    // Core side
    logic                              req_valid;
    logic                              req_write;
    logic [ADDR_WIDTH-1:0]             req_addr;
    logic [DATA_WIDTH-1:0]             req_wdata;
    logic [2:0]                        req_funct3;
    logic                              req_ready;
    logic                              resp_valid;
    logic [DATA_WIDTH-1:0]             resp_rdata;
    // Memory side
    logic                              mem_req_valid;
    logic                              mem_req_write;
    logic [ADDR_WIDTH-1:0]             mem_req_addr;
    logic [BLOCK_WORDS*DATA_WIDTH-1:0] mem_wdata;
    logic                              mem_req_ready;
    logic                              mem_resp_valid;
    logic [BLOCK_WORDS*DATA_WIDTH-1:0] mem_rdata;

    // The cache itself
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_funct3,
        output req_ready, resp_valid, resp_rdata,
        output mem_req_valid, mem_req_write, mem_req_addr, mem_wdata,
        input  mem_req_ready, mem_resp_valid, mem_rdata
    );

    // Core plus main memory, as seen from outside the cache
    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_funct3,
        input  req_ready, resp_valid, resp_rdata,
        input  mem_req_valid, mem_req_write, mem_req_addr, mem_wdata,
        output mem_req_ready, mem_resp_valid, mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/assoc_dcache.sv
`default_nettype none
// ============================================================================
//  Module      : assoc_dcache
//  Description : Set-associative write-back / write-allocate data cache with
//                a blocking miss FSM (writeback -> refill -> respond).
//  Revision    : 1.0 - initial release
// ============================================================================
module assoc_dcache #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int WAYS        = 2,
    parameter int NUM_SETS    = 128,
    parameter int BLOCK_WORDS = 4
) (
    input  wire logic     clk,
    input  wire logic     rst,
    assoc_dcache_if.slave bus
);
    localparam int c_OFF_W  = $clog2(BLOCK_WORDS);
    localparam int c_IDX_W  = $clog2(NUM_SETS);
    localparam int c_TAG_W  = ADDR_WIDTH - 2 - c_OFF_W - c_IDX_W;
    localparam int c_WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int c_LINE_W = BLOCK_WORDS * DATA_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_WRITEBACK   = 3'd1,
        S_REFILL_REQ  = 3'd2,
        S_REFILL_WAIT = 3'd3,
        S_RESPOND     = 3'd4
    } state_t;

    state_t r_state, w_state_next;

    // Per-set metadata and storage
    logic [WAYS-1:0]     r_valid [NUM_SETS];
    logic [WAYS-1:0]     r_dirty [NUM_SETS];
    logic [c_WAY_W-1:0]  r_ptr   [NUM_SETS];
    logic [c_TAG_W-1:0]  r_tag   [NUM_SETS][WAYS];
    logic [c_LINE_W-1:0] r_data  [NUM_SETS][WAYS];

    // Request latched at acceptance for use by the miss sequence
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [2:0]            r_funct3;
    logic                  r_write;
    logic [c_WAY_W-1:0]    r_victim;

    logic                  r_resp_valid;
    logic [DATA_WIDTH-1:0] r_resp_rdata;

    // Field split of the incoming and the latched address
    wire logic [c_OFF_W-1:0] w_req_off = bus.req_addr[2 +: c_OFF_W];
    wire logic [c_IDX_W-1:0] w_req_idx = bus.req_addr[2 + c_OFF_W +: c_IDX_W];
    wire logic [c_TAG_W-1:0] w_req_tag = bus.req_addr[ADDR_WIDTH-1 -: c_TAG_W];
    wire logic [c_OFF_W-1:0] w_r_off   = r_addr[2 +: c_OFF_W];
    wire logic [c_IDX_W-1:0] w_r_idx   = r_addr[2 + c_OFF_W +: c_IDX_W];
    wire logic [c_TAG_W-1:0] w_r_tag   = r_addr[ADDR_WIDTH-1 -: c_TAG_W];

    wire logic w_req_ready = (r_state == S_IDLE) && !rst;
    wire logic w_accept    = bus.req_valid && w_req_ready;
    wire logic w_fill      = (r_state == S_REFILL_WAIT) && bus.mem_resp_valid && !rst;

    logic                  w_hit;
    logic [c_WAY_W-1:0]    w_hit_way;
    logic [c_WAY_W-1:0]    w_victim;
    logic                  w_found_inv;
    logic [DATA_WIDTH-1:0] w_hit_word;
    logic [DATA_WIDTH-1:0] w_hit_merged;
    logic [c_LINE_W-1:0]   w_fill_line;
    logic [DATA_WIDTH-1:0] w_fill_old;
    logic [DATA_WIDTH-1:0] w_fill_word;

    // Merge a byte, half or word store into an existing word
    function automatic logic [DATA_WIDTH-1:0] f_store_merge(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] wdata,
        input logic [2:0]            funct3,
        input logic [1:0]            byte_off
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_word;
        case (funct3)
            3'b000:  res[{byte_off, 3'b000} +: 8]     = wdata[7:0];
            3'b001:  res[{byte_off[1], 4'b0000} +: 16] = wdata[15:0];
            default: res = wdata;
        endcase
        return res;
    endfunction

    // Select and sign/zero extend load data
    function automatic logic [DATA_WIDTH-1:0] f_load_ext(
        input logic [DATA_WIDTH-1:0] word,
        input logic [2:0]            funct3,
        input logic [1:0]            byte_off
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{byte_off, 3'b000} +: 8];
        h = word[{byte_off[1], 4'b0000} +: 16];
        case (funct3)
            3'b000:  return {{(DATA_WIDTH-8){b[7]}}, b};
            3'b001:  return {{(DATA_WIDTH-16){h[15]}}, h};
            3'b100:  return {{(DATA_WIDTH-8){1'b0}}, b};
            3'b101:  return {{(DATA_WIDTH-16){1'b0}}, h};
            default: return word;
        endcase
    endfunction

    // Tag lookup and victim choice (lowest invalid way, else round-robin pointer)
    always_comb begin
        w_hit       = 1'b0;
        w_hit_way   = '0;
        w_found_inv = 1'b0;
        w_victim    = r_ptr[w_req_idx];
        for (int w = 0; w < WAYS; w++) begin
            if (r_valid[w_req_idx][w] && (r_tag[w_req_idx][w] == w_req_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = c_WAY_W'(w);
            end
            if (!r_valid[w_req_idx][w] && !w_found_inv) begin
                w_found_inv = 1'b1;
                w_victim    = c_WAY_W'(w);
            end
        end
        w_hit_word   = r_data[w_req_idx][w_hit_way][{w_req_off, 5'b00000} +: DATA_WIDTH];
        w_hit_merged = f_store_merge(w_hit_word, bus.req_wdata, bus.req_funct3, bus.req_addr[1:0]);
    end

    // Refill line with a pending store folded in before it is installed
    always_comb begin
        w_fill_line = bus.mem_rdata;
        w_fill_old  = bus.mem_rdata[{w_r_off, 5'b00000} +: DATA_WIDTH];
        if (r_write) begin
            w_fill_line[{w_r_off, 5'b00000} +: DATA_WIDTH] =
                f_store_merge(w_fill_old, r_wdata, r_funct3, r_addr[1:0]);
        end
        w_fill_word = w_fill_line[{w_r_off, 5'b00000} +: DATA_WIDTH];
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // FSM next state and memory-side outputs
    always_comb begin
        w_state_next      = r_state;
        bus.mem_req_valid = 1'b0;
        bus.mem_req_write = 1'b0;
        bus.mem_req_addr  = '0;
        bus.mem_wdata     = '0;
        case (r_state)
            S_IDLE: begin
                if (w_accept && !w_hit) begin
                    if (r_valid[w_req_idx][w_victim] && r_dirty[w_req_idx][w_victim])
                        w_state_next = S_WRITEBACK;
                    else
                        w_state_next = S_REFILL_REQ;
                end
            end
            S_WRITEBACK: begin
                // Arrays are frozen outside IDLE, so the victim line is stable here
                bus.mem_req_valid = 1'b1;
                bus.mem_req_write = 1'b1;
                bus.mem_req_addr  = {r_tag[w_r_idx][r_victim], w_r_idx, {(c_OFF_W+2){1'b0}}};
                bus.mem_wdata     = r_data[w_r_idx][r_victim];
                if (bus.mem_req_ready) w_state_next = S_REFILL_REQ;
            end
            S_REFILL_REQ: begin
                bus.mem_req_valid = 1'b1;
                bus.mem_req_addr  = {w_r_tag, w_r_idx, {(c_OFF_W+2){1'b0}}};
                if (bus.mem_req_ready) w_state_next = S_REFILL_WAIT;
            end
            S_REFILL_WAIT: begin
                if (bus.mem_resp_valid) w_state_next = S_RESPOND;
            end
            S_RESPOND: begin
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Metadata, request latch and response register
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                r_valid[s] <= '0;
                r_dirty[s] <= '0;
                r_ptr[s]   <= '0;
            end
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            if (w_accept) begin
                r_addr   <= bus.req_addr;
                r_wdata  <= bus.req_wdata;
                r_funct3 <= bus.req_funct3;
                r_write  <= bus.req_write;
                r_victim <= w_victim;
            end
            if (w_accept && w_hit) begin
                r_resp_valid <= 1'b1;
                if (bus.req_write)
                    r_dirty[w_req_idx][w_hit_way] <= 1'b1;
                else
                    r_resp_rdata <= f_load_ext(w_hit_word, bus.req_funct3, bus.req_addr[1:0]);
            end
            if (w_fill) begin
                r_valid[w_r_idx][r_victim] <= 1'b1;
                r_dirty[w_r_idx][r_victim] <= r_write;
                r_ptr[w_r_idx] <= (r_ptr[w_r_idx] == c_WAY_W'(WAYS-1)) ? '0 : r_ptr[w_r_idx] + 1'b1;
                // Response is presented during RESPOND, one cycle after the install
                r_resp_valid <= 1'b1;
                r_resp_rdata <= r_write ? '0 : f_load_ext(w_fill_word, r_funct3, r_addr[1:0]);
            end
        end
    end

    // Data and tag arrays: store-hit merge and line install
    always_ff @(posedge clk) begin
        if (w_accept && w_hit && bus.req_write)
            r_data[w_req_idx][w_hit_way][{w_req_off, 5'b00000} +: DATA_WIDTH] <= w_hit_merged;
        if (w_fill) begin
            r_data[w_r_idx][r_victim] <= w_fill_line;
            r_tag[w_r_idx][r_victim]  <= w_r_tag;
        end
    end

    assign bus.req_ready  = w_req_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_rdata = r_resp_rdata;
endmodule
`default_nettype wire

// File: tb/tb_assoc_dcache.sv
`default_nettype none
// ============================================================================
//  Module      : tb_assoc_dcache
//  Description : Directed self-checking bench for assoc_dcache with a flat
//                reference memory, a backing-memory responder and a response
//                scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_assoc_dcache;
    logic clk = 1'b0;
    logic rst = 1'b1;

    assoc_dcache_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .BLOCK_WORDS(4)) bus ();

    assoc_dcache #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .WAYS(2), .NUM_SETS(128), .BLOCK_WORDS(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Free-running clock
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference view of memory as the core should see it, and the backing store
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] bk_mem  [logic [31:0]];

    logic [31:0] exp_q [$];
    string       tag_q [$];
    int          resp_count = 0;

    int           mem_reads = 0, mem_writes = 0;
    logic [31:0]  last_rd_addr = '0, last_wb_addr = '0;
    logic [127:0] last_wb_line = '0;
    int           wb_stall_cycles = 0;
    int           wb_wait = 0;
    bit           hold_resp = 1'b0;
    bit           pend = 1'b0;
    int           pend_cnt = 0;
    logic [31:0]  pend_addr = '0;
    bit           stalled_prev = 1'b0;
    logic [31:0]  held_addr = '0;
    logic [127:0] held_wdata = '0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {8'h5A, a[23:0]};
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] bk_read(input logic [31:0] a);
        return bk_mem.exists(a) ? bk_mem[a] : init_word(a);
    endfunction

    function automatic logic [127:0] ref_line(input logic [31:0] a);
        logic [127:0] l;
        for (int i = 0; i < 4; i++) l[32*i +: 32] = ref_read(a + 32'(4*i));
        return l;
    endfunction

    function automatic logic [127:0] bk_line(input logic [31:0] a);
        logic [127:0] l;
        for (int i = 0; i < 4; i++) l[32*i +: 32] = bk_read(a + 32'(4*i));
        return l;
    endfunction

    function automatic logic [31:0] tb_store(input logic [31:0] old, input logic [31:0] wd,
                                             input logic [2:0] f3, input logic [1:0] bo);
        logic [31:0] r;
        r = old;
        case (f3)
            3'b000:  r[8*int'(bo) +: 8] = wd[7:0];
            3'b001:  if (bo[1]) r[31:16] = wd[15:0]; else r[15:0] = wd[15:0];
            default: r = wd;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] tb_load(input logic [31:0] w, input logic [2:0] f3,
                                            input logic [1:0] bo);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(w >> (8*int'(bo)));
        h = bo[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'h0, b};
            3'b101:  return {16'h0, h};
            default: return w;
        endcase
    endfunction

    // Scoreboard: every response must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (bus.resp_valid === 1'b1) begin
            check("resp_expected", 128'(exp_q.size() != 0), 128'(1));
            if (exp_q.size() != 0) begin
                check(tag_q.pop_front(), 128'(bus.resp_rdata), 128'(exp_q.pop_front()));
            end
            resp_count++;
        end
    end

    // Main-memory model: optional writeback backpressure, refill after two idle cycles
    always @(negedge clk) begin
        bus.mem_resp_valid = 1'b0;
        bus.mem_req_ready  = 1'b0;
        if (rst) begin
            pend = 1'b0;
            wb_wait = 0;
            stalled_prev = 1'b0;
        end else begin
            if (stalled_prev) begin
                check("stall_mem_valid", 128'(bus.mem_req_valid), 128'(1));
                check("stall_addr_stable", 128'(bus.mem_req_addr), 128'(held_addr));
                check("stall_wdata_stable", bus.mem_wdata, held_wdata);
                check("stall_req_ready", 128'(bus.req_ready), 128'(0));
                check("stall_no_resp", 128'(bus.resp_valid), 128'(0));
            end
            stalled_prev = 1'b0;
            if (bus.mem_req_valid === 1'b1) begin
                if (bus.mem_req_write && wb_wait < wb_stall_cycles) begin
                    wb_wait++;
                    stalled_prev = 1'b1;
                    held_addr  = bus.mem_req_addr;
                    held_wdata = bus.mem_wdata;
                end else begin
                    bus.mem_req_ready = 1'b1;
                    wb_wait = 0;
                    if (bus.mem_req_write) begin
                        mem_writes++;
                        last_wb_addr = bus.mem_req_addr;
                        last_wb_line = bus.mem_wdata;
                        check("wb_line_content", bus.mem_wdata, ref_line(bus.mem_req_addr));
                        for (int i = 0; i < 4; i++)
                            bk_mem[bus.mem_req_addr + 32'(4*i)] = bus.mem_wdata[32*i +: 32];
                    end else begin
                        mem_reads++;
                        last_rd_addr = bus.mem_req_addr;
                        pend = 1'b1;
                        pend_cnt = 2;
                        pend_addr = bus.mem_req_addr;
                    end
                end
            end else if (pend && !hold_resp) begin
                if (pend_cnt == 0) begin
                    bus.mem_resp_valid = 1'b1;
                    bus.mem_rdata = bk_line(pend_addr);
                    pend = 1'b0;
                end else begin
                    pend_cnt--;
                end
            end
        end
    end

    // One core access: predict, issue, wait for response, check memory traffic
    task automatic access(input bit wr, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int exp_rd, input int exp_wr,
                          input string tag);
        logic [31:0] e;
        logic [31:0] wa;
        int rd0, wr0, r0, n;
        wa = {a[31:2], 2'b00};
        if (wr) begin
            ref_mem[wa] = tb_store(ref_read(wa), wd, f3, a[1:0]);
            e = '0;
        end else begin
            e = tb_load(ref_read(wa), f3, a[1:0]);
        end
        exp_q.push_back(e);
        tag_q.push_back({tag, "_data"});
        @(negedge clk); #1;
        bus.req_valid = 1'b1; bus.req_write = wr; bus.req_addr = a;
        bus.req_wdata = wd;   bus.req_funct3 = f3;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 200) begin @(negedge clk); #1; n++; end
        check({tag, "_accept"}, 128'(n < 200), 128'(1));
        rd0 = mem_reads; wr0 = mem_writes; r0 = resp_count;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        if (exp_rd == 0 && exp_wr == 0) begin
            @(negedge clk);
            check({tag, "_hit_latency"}, 128'(bus.resp_valid), 128'(1));
            #1;
        end else begin
            n = 0;
            while (resp_count == r0 && n < 200) begin @(negedge clk); #1; n++; end
            check({tag, "_miss_resp"}, 128'(resp_count - r0), 128'(1));
        end
        check({tag, "_mem_reads"}, 128'(mem_reads - rd0), 128'(exp_rd));
        check({tag, "_mem_writes"}, 128'(mem_writes - wr0), 128'(exp_wr));
    endtask

    // Directed sequence
    initial begin
        int n, rd0;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0;
        bus.req_wdata = '0;   bus.req_funct3 = 3'b010;
        bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0; bus.mem_rdata = '0;
        bk_mem[32'h100] = 32'h11111111;
        bk_mem[32'h104] = 32'h22222222;
        bk_mem[32'h108] = 32'h33333333;
        bk_mem[32'h10C] = 32'h44444444;
        ref_mem = bk_mem;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_req_ready", 128'(bus.req_ready), 128'(1));
        check("rst_resp_valid", 128'(bus.resp_valid), 128'(0));
        check("rst_resp_rdata", 128'(bus.resp_rdata), 128'(0));
        check("rst_mem_valid", 128'(bus.mem_req_valid), 128'(0));
        check("rst_mem_addr", 128'(bus.mem_req_addr), 128'(0));
        check("rst_mem_wdata", bus.mem_wdata, 128'(0));

        // Cold miss then hit in the same line
        access(1'b0, 3'b010, 32'h100, 32'h0, 1, 0, "lw_100_miss");
        check("refill_addr_100", 128'(last_rd_addr), 128'(32'h100));
        access(1'b0, 3'b010, 32'h104, 32'h0, 0, 0, "lw_104_hit");

        // Byte store and sign/zero-extended reloads
        access(1'b1, 3'b000, 32'h101, 32'h000000AB, 0, 0, "sb_101");
        access(1'b0, 3'b100, 32'h101, 32'h0, 0, 0, "lbu_101");
        access(1'b0, 3'b000, 32'h101, 32'h0, 0, 0, "lb_101");
        access(1'b0, 3'b010, 32'h100, 32'h0, 0, 0, "lw_100_neigh");
        access(1'b0, 3'b001, 32'h10E, 32'h0, 0, 0, "lh_10e");

        // Conflict set 0x10: dirty way 0, fill way 1, evict way 0 under backpressure
        access(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, "sw_100");
        access(1'b0, 3'b010, 32'h900, 32'h0, 1, 0, "lw_900_fill");
        wb_stall_cycles = 5;
        access(1'b0, 3'b010, 32'h1100, 32'h0, 1, 1, "lw_1100_evict");
        wb_stall_cycles = 0;
        check("wb_addr_100", 128'(last_wb_addr), 128'(32'h100));
        check("wb_word0", 128'(last_wb_line[31:0]), 128'(32'hDEADBEEF));
        check("refill_addr_1100", 128'(last_rd_addr), 128'(32'h1100));

        // Write-allocate half store, reload, then force its eviction
        access(1'b1, 3'b001, 32'h106, 32'h0000BEEF, 1, 0, "sh_106_miss");
        access(1'b0, 3'b101, 32'h106, 32'h0, 0, 0, "lhu_106");
        access(1'b0, 3'b010, 32'h1900, 32'h0, 1, 0, "lw_1900");
        access(1'b0, 3'b010, 32'h2100, 32'h0, 1, 1, "lw_2100_evict");
        check("wb2_addr", 128'(last_wb_addr), 128'(32'h100));
        check("wb2_half", 128'(last_wb_line[63:48]), 128'(16'hBEEF));

        // Back-to-back hits
        exp_q.push_back(tb_load(ref_read(32'h1900), 3'b010, 2'b00)); tag_q.push_back("b2b_0_data");
        exp_q.push_back(tb_load(ref_read(32'h1904), 3'b010, 2'b00)); tag_q.push_back("b2b_1_data");
        @(negedge clk); #1;
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_funct3 = 3'b010; bus.req_addr = 32'h1900;
        check("b2b_ready0", 128'(bus.req_ready), 128'(1));
        @(posedge clk); #1;
        bus.req_addr = 32'h1904;
        @(negedge clk);
        check("b2b_resp0", 128'(bus.resp_valid), 128'(1));
        check("b2b_ready1", 128'(bus.req_ready), 128'(1));
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("b2b_resp1", 128'(bus.resp_valid), 128'(1));

        // Reset while waiting for refill data
        hold_resp = 1'b1;
        @(negedge clk); #1;
        rd0 = mem_reads;
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_funct3 = 3'b010; bus.req_addr = 32'h3000;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        n = 0;
        while (mem_reads == rd0 && n < 50) begin @(negedge clk); #1; n++; end
        check("abandon_refill_issued", 128'(mem_reads - rd0), 128'(1));
        @(posedge clk); #1;
        check("abandon_wait_busy", 128'(bus.req_ready), 128'(0));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abandon_mem_valid", 128'(bus.mem_req_valid), 128'(0));
        check("abandon_req_ready", 128'(bus.req_ready), 128'(1));
        hold_resp = 1'b0;
        ref_mem = bk_mem;
        access(1'b0, 3'b010, 32'h104, 32'h0, 1, 0, "lw_104_after_rst");

        repeat (4) @(negedge clk);
        check("scoreboard_empty", 128'(exp_q.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Global time limit
    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
